// File: rtl/uart_serial_dev.sv
// Device-side 8N1/8E1/8O1/8x2 UART with 16x oversampling and valid/ready byte ports.
// TX uses a prescaler restarted on accept; RX uses a free-running prescaler.
module uart_serial_dev #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [DIV_WIDTH-1:0] clkdiv_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 two_stop_i,
  input  logic [7:0]           tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_frame_err_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_overrun_o,
  input  logic                 err_clr_i,
  output logic                 rx_busy_o,
  output logic                 stx_pad_o,
  input  logic                 srx_pad_i
);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t            tx_st, tx_nx;
  logic [DIV_WIDTH-1:0] tx_pre;
  logic [3:0]           tx_tcnt;
  logic [2:0]           tx_bit, tx_bit_nx;
  logic [7:0]           tx_sh;
  logic                 tx_pen, tx_podd, tx_two, tx_stop2;
  logic                 tx_tick, tx_bit_end, tx_accept, tx_line;

  assign tx_ready_o = (tx_st == T_IDLE);
  assign tx_busy_o  = ~tx_ready_o;
  assign tx_accept  = tx_valid_i & tx_ready_o;
  assign tx_tick    = (tx_pre == clkdiv_i);
  assign tx_bit_end = tx_tick & (tx_tcnt == 4'd15);

  always_comb begin
    tx_nx     = tx_st;
    tx_bit_nx = tx_bit;
    tx_line   = 1'b1;
    case (tx_st)
      T_IDLE:  if (tx_accept) begin
                 tx_nx     = T_START;
                 tx_bit_nx = 3'd0;
               end
      T_START: if (tx_bit_end) tx_nx = T_DATA;
      T_DATA:  if (tx_bit_end) begin
                 tx_bit_nx = tx_bit + 3'd1;
                 if (tx_bit == 3'd7) tx_nx = tx_pen ? T_PAR : T_STOP;
               end
      T_PAR:   if (tx_bit_end) tx_nx = T_STOP;
      T_STOP:  if (tx_bit_end && (!tx_two || tx_stop2)) tx_nx = T_IDLE;
      default: tx_nx = T_IDLE;
    endcase
    // pad is registered from the next state so it never glitches
    case (tx_nx)
      T_START: tx_line = 1'b0;
      T_DATA:  tx_line = tx_sh[tx_bit_nx];
      T_PAR:   tx_line = (^tx_sh) ^ tx_podd;
      default: tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tx_st     <= T_IDLE;
      tx_pre    <= '0;
      tx_tcnt   <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      tx_pen    <= 1'b0;
      tx_podd   <= 1'b0;
      tx_two    <= 1'b0;
      tx_stop2  <= 1'b0;
      stx_pad_o <= 1'b1;
    end else begin
      tx_st     <= tx_nx;
      tx_bit    <= tx_bit_nx;
      stx_pad_o <= tx_line;
      if (tx_accept) begin
        tx_pre   <= '0;
        tx_tcnt  <= '0;
        tx_sh    <= tx_data_i;
        tx_pen   <= parity_en_i;
        tx_podd  <= parity_odd_i;
        tx_two   <= two_stop_i;
        tx_stop2 <= 1'b0;
      end else if (tx_st != T_IDLE) begin
        tx_pre <= tx_tick ? '0 : tx_pre + 1'b1;
        if (tx_tick) tx_tcnt <= tx_tcnt + 4'd1;
        if (tx_bit_end && tx_st == T_STOP) tx_stop2 <= 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_st, rx_nx;
  logic [DIV_WIDTH-1:0] rx_pre;
  logic [3:0]           rx_tcnt;
  logic [2:0]           rx_bit;
  logic [7:0]           rx_sh;
  logic                 rx_s1, rx_s2, rx_par;
  logic                 rx_tick, rx_mid, rx_done, rx_consume;

  assign rx_busy_o  = (rx_st != R_IDLE);
  assign rx_tick    = (rx_pre == clkdiv_i);
  assign rx_mid     = rx_tick & (rx_tcnt == 4'd15);
  assign rx_consume = rx_valid_o & rx_ready_i;

  always_comb begin
    rx_nx   = rx_st;
    rx_done = 1'b0;
    case (rx_st)
      R_IDLE:  if (rx_tick && !rx_s2) rx_nx = R_START;
      R_START: if (rx_tick && rx_tcnt == 4'd7) rx_nx = rx_s2 ? R_IDLE : R_DATA;
      R_DATA:  if (rx_mid && rx_bit == 3'd7) rx_nx = parity_en_i ? R_PAR : R_STOP;
      R_PAR:   if (rx_mid) rx_nx = R_STOP;
      R_STOP:  if (rx_mid) begin
                 rx_nx   = R_IDLE;
                 rx_done = 1'b1;
               end
      default: rx_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rx_s1           <= 1'b1;
      rx_s2           <= 1'b1;
      rx_st           <= R_IDLE;
      rx_pre          <= '0;
      rx_tcnt         <= '0;
      rx_bit          <= '0;
      rx_sh           <= '0;
      rx_par          <= 1'b0;
      rx_data_o       <= '0;
      rx_valid_o      <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_parity_err_o <= 1'b0;
      rx_overrun_o    <= 1'b0;
    end else begin
      rx_s1  <= srx_pad_i;
      rx_s2  <= rx_s1;
      rx_st  <= rx_nx;
      rx_pre <= rx_tick ? '0 : rx_pre + 1'b1;
      if (rx_tick) begin
        // count restarts at mid start bit so each later sample lands 16 ticks on
        if (rx_st == R_IDLE || (rx_st == R_START && rx_tcnt == 4'd7)) rx_tcnt <= '0;
        else rx_tcnt <= rx_tcnt + 4'd1;
        if (rx_st == R_START) rx_bit <= '0;
        if (rx_st == R_DATA && rx_tcnt == 4'd15) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 3'd1;
        end
        if (rx_st == R_PAR && rx_tcnt == 4'd15) rx_par <= rx_s2;
      end
      if (rx_done) begin
        rx_data_o       <= rx_sh;
        rx_valid_o      <= 1'b1;
        rx_frame_err_o  <= ~rx_s2;
        rx_parity_err_o <= parity_en_i & (rx_par != ((^rx_sh) ^ parity_odd_i));
      end else if (rx_consume) begin
        rx_valid_o      <= 1'b0;
        rx_frame_err_o  <= 1'b0;
        rx_parity_err_o <= 1'b0;
      end
      if (rx_done && rx_valid_o && !rx_ready_i) rx_overrun_o <= 1'b1;
      else if (err_clr_i) rx_overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_serial_dev.sv
// Directed bench for uart_serial_dev: TX waveform, RX frames, errors, overrun,
// internal loopback and mid-frame reset. Bit period is 64 clocks (clkdiv=3).
module tb_uart_serial_dev;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [15:0] clkdiv;
  logic       parity_en, parity_odd, two_stop;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_frame_err, rx_parity_err, rx_overrun;
  logic       err_clr, rx_busy, stx, srx, srx_drv, loop;

  int checks = 0;
  int errors = 0;

  assign srx = loop ? stx : srx_drv;

  always #5 clk = ~clk;

  uart_serial_dev #(.DIV_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clkdiv_i(clkdiv),
    .parity_en_i(parity_en), .parity_odd_i(parity_odd), .two_stop_i(two_stop),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_busy_o(tx_busy),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .rx_frame_err_o(rx_frame_err), .rx_parity_err_o(rx_parity_err),
    .rx_overrun_o(rx_overrun), .err_clr_i(err_clr), .rx_busy_o(rx_busy),
    .stx_pad_o(stx), .srx_pad_i(srx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one serial frame on srx, 64 clocks per bit, starting at a negedge.
  task automatic send_rx(input logic [7:0] d, input logic pen, input logic bad_par,
                         input logic stop_v);
    srx_drv = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      srx_drv = d[i];
      repeat (64) @(negedge clk);
    end
    if (pen) begin
      srx_drv = (^d) ^ parity_odd ^ bad_par;
      repeat (64) @(negedge clk);
    end
    srx_drv = stop_v;
    repeat (64) @(negedge clk);
    srx_drv = 1'b1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_rx_valid(input string tag);
    int n = 0;
    while (rx_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, rx_valid}, 32'd1);
  endtask

  // Accept one byte on TX and return the number of clocks until tx_ready returns.
  task automatic send_tx(input logic [7:0] d, output int len);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    len = 0;
    while (tx_ready !== 1'b1 && len < 3000) begin
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] lb [4];
    int len;
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h81; lb[3] = 8'h7E;
    rst_n = 1'b0; clkdiv = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
    srx_drv = 1'b1; loop = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stx", {31'd0, stx}, 32'd1);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_errs", {29'd0, rx_frame_err, rx_parity_err, rx_overrun}, 32'd0);
    chk("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // TX 0xA5, no parity, 1 stop: every clock of the 640-clock frame is checked.
    frame = {1'b1, 8'hA5, 1'b0};
    tx_data = 8'hA5; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_busy_after_accept", {31'd0, tx_busy}, 32'd1);
    for (int k = 0; k < 640; k++) begin
      chk($sformatf("tx_bit_clk%0d", k), {31'd0, stx}, {31'd0, frame[k/64]});
      chk($sformatf("tx_ready_clk%0d", k), {31'd0, tx_ready}, 32'd0);
      @(negedge clk);
    end
    chk("tx_ready_return", {31'd0, tx_ready}, 32'd1);
    chk("tx_busy_return", {31'd0, tx_busy}, 32'd0);
    repeat (20) @(negedge clk);

    // RX 0x3C with odd parity, then with a corrupted parity bit.
    parity_en = 1'b1; parity_odd = 1'b1;
    send_rx(8'h3C, 1'b1, 1'b0, 1'b1);
    chk("rx_odd_valid", {31'd0, rx_valid}, 32'd1);
    chk("rx_odd_data", {24'd0, rx_data}, 32'h3C);
    chk("rx_odd_errs", {30'd0, rx_frame_err, rx_parity_err}, 32'd0);
    consume();
    chk("rx_consumed", {31'd0, rx_valid}, 32'd0);
    repeat (20) @(negedge clk);
    send_rx(8'h3C, 1'b1, 1'b1, 1'b1);
    chk("rx_badpar_data", {24'd0, rx_data}, 32'h3C);
    chk("rx_badpar_flag", {31'd0, rx_parity_err}, 32'd1);
    chk("rx_badpar_frame", {31'd0, rx_frame_err}, 32'd0);
    consume();
    repeat (20) @(negedge clk);

    // Framing error: stop bit driven low.
    parity_en = 1'b0;
    send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("rx_ferr_valid", {31'd0, rx_valid}, 32'd1);
    chk("rx_ferr_data", {24'd0, rx_data}, 32'h5A);
    chk("rx_ferr_flag", {31'd0, rx_frame_err}, 32'd1);
    repeat (200) @(negedge clk);
    chk("rx_ferr_idle", {31'd0, rx_busy}, 32'd0);
    consume();
    repeat (20) @(negedge clk);

    // 4-tick low glitch: start detected, then rejected at mid-start.
    srx_drv = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_busy", {31'd0, rx_busy}, 32'd1);
    repeat (4) @(negedge clk);
    srx_drv = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_idle", {31'd0, rx_busy}, 32'd0);

    // Overrun: two back-to-back bytes with nobody reading.
    send_rx(8'h11, 1'b0, 1'b0, 1'b1);
    send_rx(8'h22, 1'b0, 1'b0, 1'b1);
    chk("ovr_data", {24'd0, rx_data}, 32'h22);
    chk("ovr_flag", {31'd0, rx_overrun}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovr_clear", {31'd0, rx_overrun}, 32'd0);
    consume();
    repeat (20) @(negedge clk);

    // Same pair, but the reader takes 0x11 exactly as 0x22 completes. With
    // 640-clock frames and a 4-clock tick, completion of 0x22 lands 640 clocks
    // after that of 0x11.
    fork
      begin
        send_rx(8'h11, 1'b0, 1'b0, 1'b1);
        send_rx(8'h22, 1'b0, 1'b0, 1'b1);
      end
      begin
        wait_rx_valid("ovr2_first_valid");
        repeat (639) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    chk("ovr2_valid", {31'd0, rx_valid}, 32'd1);
    chk("ovr2_data", {24'd0, rx_data}, 32'h22);
    chk("ovr2_no_overrun", {31'd0, rx_overrun}, 32'd0);
    consume();
    repeat (20) @(negedge clk);

    // Loopback, even parity, two stop bits: 12 bits per frame.
    loop = 1'b1; parity_en = 1'b1; parity_odd = 1'b0; two_stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_tx(lb[i], len);
      chk($sformatf("lb_len%0d", i), len, 32'd768);
      wait_rx_valid($sformatf("lb_valid%0d", i));
      chk($sformatf("lb_data%0d", i), {24'd0, rx_data}, {24'd0, lb[i]});
      chk($sformatf("lb_errs%0d", i), {29'd0, rx_frame_err, rx_parity_err, rx_overrun}, 32'd0);
      if (i < 3) consume();
      repeat (10) @(negedge clk);
    end

    // Reset during TX bit 4 and RX bit 4; last loopback byte is still held.
    loop = 1'b0; parity_en = 1'b0; two_stop = 1'b0;
    tx_data = 8'h5A; tx_valid = 1'b1; srx_drv = 1'b0;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (351) @(negedge clk);
    chk("pre_rst_busy", {30'd0, tx_busy, rx_busy}, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; srx_drv = 1'b1;
    chk("mid_rst_stx", {31'd0, stx}, 32'd1);
    chk("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("mid_rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    repeat (20) @(negedge clk);

    loop = 1'b1;
    send_tx(8'hC3, len);
    chk("post_rst_len", len, 32'd640);
    wait_rx_valid("post_rst_valid");
    chk("post_rst_data", {24'd0, rx_data}, 32'hC3);
    chk("post_rst_errs", {29'd0, rx_frame_err, rx_parity_err, rx_overrun}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_serial_dev.md
# uart_serial_dev

Synthesizable device-side UART: 8-bit transmitter and receiver with 16x oversampling. It sits inside the design under test and talks to `uart_serial_bfm` over the serial pads. `stx_pad_o` connects to the BFM's `srx_pad_i`, and the BFM's `stx_pad_o` connects to `srx_pad_i`. Byte traffic to and from the fabric uses valid/ready handshakes; baud rate and framing are set by static configuration inputs.

## Interface
- `DIV_WIDTH`, default 16: width of the baud divisor.
- `clk_i`  in  1  system clock; all logic is on its rising edge.
- `rst_n_i`  in  1  synchronous reset, active-low.
- `clkdiv_i`  in  DIV_WIDTH  16x tick period minus one, in clocks. Must be stable while `tx_busy_o` or `rx_busy_o` is high.
- `parity_en_i`  in  1  enables a parity bit after the data bits.
- `parity_odd_i`  in  1  1 selects odd parity; 0 selects even.
- `two_stop_i`  in  1  TX sends 2 stop bits when set. RX always checks only the first stop bit.
- `tx_data_i`  in  8  byte to transmit.
- `tx_valid_i`  in  1  `tx_data_i` is valid.
- `tx_ready_o`  out  1  transmitter is idle and can accept a byte.
- `tx_busy_o`  out  1  frame is in progress on `stx_pad_o`.
- `rx_data_o`  out  8  received byte in the holding register.
- `rx_valid_o`  out  1  holding register is full.
- `rx_ready_i`  in  1  consumer takes the byte.
- `rx_frame_err_o`  out  1  stop-bit error for the byte in the holding register.
- `rx_parity_err_o`  out  1  parity error for the byte in the holding register.
- `rx_overrun_o`  out  1  sticky flag: a byte was overwritten before it was read.
- `err_clr_i`  in  1  clears `rx_overrun_o`.
- `rx_busy_o`  out  1  RX frame is in progress.
- `stx_pad_o`  out  1  serial output; idles high.
- `srx_pad_i`  in  1  serial input; asynchronous.

## Operation
- **Ticks:** a prescaler counts 0..`clkdiv_i` and emits a 1-clock tick when the count equals `clkdiv_i`. One bit lasts 16 ticks, which is 16*(`clkdiv_i`+1) clocks. `clkdiv_i`=0 produces a tick every clock.
- **Separate prescalers:**
  - TX has its own prescaler. It is cleared on byte accept, so every TX bit is exactly 16*(`clkdiv_i`+1) clocks.
  - RX has a free-running prescaler.
- **TX state machine:** IDLE → START → DATA(×8, LSB first) → PARITY (only if `parity_en_i`) → STOP(×1 or ×2) → IDLE.
  - A byte is accepted when `tx_valid_i` && `tx_ready_o` are both high on a clock edge. `tx_data_i` and the configuration inputs are latched at that edge.
  - Parity bit is XOR of the data bits, inverted when `parity_odd_i` is set.
- **RX input sync:** `srx_pad_i` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- **RX state machine:** IDLE → START → DATA → PARITY → STOP → IDLE. Every RX step happens on an RX tick.
  - IDLE: a low sample moves to START and clears the tick count.
  - START: at tick count 7 (mid start bit) the line is rechecked. High means a false start: return to IDLE with no output. Low continues to the data bits.
  - Data: each data bit is sampled 16 ticks after the previous sample, LSB first.
  - Parity: if `parity_en_i`, the parity bit is sampled next and compared.
  - STOP: the stop bit is sampled. A 0 sets the frame error for that byte.
  - After the stop sample the machine returns to IDLE immediately, so it can resync on a back-to-back start bit.
- **RX holding register:** on the stop sample, load `rx_data_o`, `rx_frame_err_o` and `rx_parity_err_o`, and set `rx_valid_o`.
  - The byte is consumed when `rx_valid_o` && `rx_ready_i` on a clock edge; `rx_valid_o` then clears.
  - If a new byte completes while `rx_valid_o` is high and `rx_ready_i` is low, the new byte overwrites the old one and `rx_overrun_o` is set.
  - If a new byte completes in the same cycle as a consume, there is no overrun; the new byte loads and `rx_valid_o` stays 1.
  - If `err_clr_i` and a new overrun occur in the same cycle, the overrun wins and `rx_overrun_o` stays 1.
- **Reset:**
  - Outputs reset to: `stx_pad_o`=1, `tx_ready_o`=1, `tx_busy_o`=0, `rx_valid_o`=0, `rx_data_o`=0, all three error flags 0, `rx_busy_o`=0.
  - Both state machines go to IDLE and both prescalers clear.
  - Reset in the middle of a frame aborts it. `stx_pad_o` is high on the first clock after reset.

## Timing
- **TX accept to start bit:** `stx_pad_o` goes low on the clock after the accept edge. `tx_ready_o` drops and `tx_busy_o` rises at that same edge.
- **TX frame length:** the frame lasts (1+8+P+S)×16×(`clkdiv_i`+1) clocks, where P is 1 if parity is enabled and S is 1 or 2 stop bits.
  - `tx_ready_o` returns to 1 and `tx_busy_o` to 0 on the clock after the last stop bit ends.
  - A new accept in that cycle starts the next start bit with no idle gap.
- **RX output latency:** `rx_valid_o` is asserted 1 clock after the stop-bit sample tick.
  - The stop-bit sample is about 8 ticks plus the 2-cycle synchronizer delay into the stop bit.
  - `rx_busy_o` is high from start detection until the stop sample.
- **RX tolerance:** RX must accept frames whose bit period is within ±3% of nominal.

## Test plan
- **TX, no parity:** `clkdiv_i`=3, no parity, 1 stop, send 0xA5 → `stx_pad_o` shows 0 for 64 clocks, then bits 1,0,1,0,0,1,0,1 at 64 clocks each, then 1 for 64 clocks. `tx_ready_o` returns 640 clocks after the low edge.
- **RX, odd parity:** drive the frame for 0x3C on `srx_pad_i` with odd parity, `parity_en_i`=`parity_odd_i`=1 → `rx_data_o`=0x3C, `rx_valid_o`=1, both error flags 0. Repeat with a corrupted parity bit → `rx_parity_err_o`=1.
- **RX framing error and glitch:** drive the stop bit as 0 → `rx_frame_err_o`=1 with data intact. Drive a 4-tick low glitch → no `rx_valid_o`, and the RX machine returns to IDLE.
- **Overrun:** send 0x11 and then 0x22 back-to-back with `rx_ready_i`=0 → `rx_data_o`=0x22, `rx_overrun_o`=1. Pulse `err_clr_i` → `rx_overrun_o`=0. Repeat with `rx_ready_i` asserted exactly on the completion cycle of 0x22 → no overrun.
- **Loopback with `uart_serial_bfm`:** connect to `uart_serial_bfm` with matching divisors and pass 256 bytes 0x00..0xFF each way → all bytes match in order with no error flags.
- **Reset mid-frame:** assert `rst_n_i`=0 during TX bit 4 and RX bit 4 → `stx_pad_o`=1, `tx_ready_o`=1, `rx_valid_o`=0 on the next clock. A following frame completes correctly.
